// File: rtl/syn_fft_pkg.sv
// Shared definitions for the fusiform gyrus FFT ping-pong cache and its host agent.
package syn_fft_pkg;
  localparam int C_ADDR_W      = 8;
  localparam int C_NUM_SAMPLES = 1 << C_ADDR_W;

  typedef enum logic [1:0] {ST_INIT, ST_FILL, ST_READY, ST_DRAIN} fft_hst_agent_st_t;
endpackage

// File: rtl/syn_fgyrus_hst_skid_fifo.sv
// Small synchronous skid FIFO; occupancy is exported so the reader can meter its requests.
module syn_fgyrus_hst_skid_fifo #(
  parameter  int P_W     = 33,
  parameter  int P_DEPTH = 4,
  localparam int CW      = $clog2(P_DEPTH + 1),
  localparam int PW      = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic [P_W-1:0] push_data,
  input  logic           pop,
  output logic [P_W-1:0] head,
  output logic           empty,
  output logic [CW-1:0]  count
);
  logic [P_W-1:0] mem [P_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic           full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(P_DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(P_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(P_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/syn_fgyrus_fft_cache_hst_agent.sv
// Host-port master for the FFT ping-pong cache: drains each finished frame as a
// flow-controlled result stream, then refills the buffer with the next PCM frame.
module syn_fgyrus_fft_cache_hst_agent
  import syn_fft_pkg::*;
#(
  parameter int P_DATA_W     = 32,
  parameter int P_ADDR_W     = C_ADDR_W,
  parameter int P_NUM_SAMPLES = C_NUM_SAMPLES,
  parameter int P_RD_DELAY   = 2,
  parameter int P_FIFO_DEPTH = 4
) (
  input  logic                clk_ir,
  input  logic                rst_ir,
  input  logic                fft_done_i,
  output logic [P_ADDR_W-1:0] hst_addr_o,
  output logic                hst_rd_en_o,
  output logic                hst_wr_en_o,
  output logic [P_DATA_W-1:0] hst_wr_data_o,
  input  logic [P_DATA_W-1:0] hst_rd_data_i,
  input  logic                hst_rd_valid_i,
  input  logic                pcm_valid_i,
  input  logic [P_DATA_W-1:0] pcm_data_i,
  output logic                pcm_ready_o,
  output logic                res_valid_o,
  output logic [P_DATA_W-1:0] res_data_o,
  output logic                res_last_o,
  input  logic                res_ready_i,
  output logic                fill_done_o,
  output logic                sync_err_o
);
  localparam int CNT_W = P_ADDR_W + 1;
  localparam int FCW   = $clog2(P_FIFO_DEPTH + 1);
  localparam int OCW   = $clog2(P_FIFO_DEPTH + P_RD_DELAY + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(P_NUM_SAMPLES - 1);

  fft_hst_agent_st_t state;
  logic [CNT_W-1:0]  fill_cnt, rd_cnt, ret_cnt;
  logic [OCW-1:0]    out_cnt;

  logic              fifo_push, fifo_pop, fifo_empty, credit, pcm_hs, rd_match;
  logic [P_DATA_W:0] fifo_head;
  logic [FCW-1:0]    fifo_cnt;
  logic [31:0]       in_flight;

  // Returns with nothing outstanding are stray and never enter the FIFO.
  assign rd_match  = hst_rd_valid_i && (out_cnt != '0);
  assign fifo_push = rd_match;
  assign fifo_pop  = res_valid_o && res_ready_i;
  assign pcm_hs    = (state == ST_FILL) && pcm_ready_o && pcm_valid_i;

  syn_fgyrus_hst_skid_fifo #(.P_W(P_DATA_W + 1), .P_DEPTH(P_FIFO_DEPTH)) u_fifo (
    .clk       (clk_ir),
    .rst       (rst_ir),
    .push      (fifo_push),
    .push_data ({ret_cnt == LAST, hst_rd_data_i}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign res_valid_o = !fifo_empty;
  assign res_data_o  = fifo_empty ? '0 : fifo_head[P_DATA_W-1:0];
  assign res_last_o  = !fifo_empty && fifo_head[P_DATA_W];

  // Every read already in flight, including the one on the port now, owns a FIFO slot.
  always_comb begin
    in_flight = 32'(out_cnt) + 32'(hst_rd_en_o) + 32'(fifo_cnt) - 32'(fifo_pop);
    credit    = in_flight < 32'(P_FIFO_DEPTH);
  end

  always_ff @(posedge clk_ir or posedge rst_ir) begin
    if (rst_ir) begin
      state         <= ST_INIT;
      fill_cnt      <= '0;
      rd_cnt        <= '0;
      ret_cnt       <= '0;
      out_cnt       <= '0;
      hst_addr_o    <= '0;
      hst_rd_en_o   <= 1'b0;
      hst_wr_en_o   <= 1'b0;
      hst_wr_data_o <= '0;
      pcm_ready_o   <= 1'b0;
      fill_done_o   <= 1'b0;
      sync_err_o    <= 1'b0;
    end else begin
      hst_wr_en_o <= 1'b0;
      hst_rd_en_o <= 1'b0;
      fill_done_o <= 1'b0;
      if (fft_done_i && state != ST_READY) sync_err_o <= 1'b1;
      if (hst_rd_valid_i && out_cnt == '0) sync_err_o <= 1'b1;
      if (hst_rd_en_o && !rd_match)      out_cnt <= out_cnt + OCW'(1);
      else if (!hst_rd_en_o && rd_match) out_cnt <= out_cnt - OCW'(1);
      if (fifo_push) ret_cnt <= ret_cnt + CNT_W'(1);

      case (state)
        ST_INIT: begin
          state    <= ST_FILL;
          fill_cnt <= '0;
        end
        ST_FILL: begin
          pcm_ready_o <= !(pcm_hs && fill_cnt == LAST);
          if (pcm_hs) begin
            hst_wr_en_o   <= 1'b1;
            hst_addr_o    <= fill_cnt[P_ADDR_W-1:0];
            hst_wr_data_o <= pcm_data_i;
            fill_cnt      <= fill_cnt + CNT_W'(1);
            if (fill_cnt == LAST) begin
              fill_done_o <= 1'b1;
              state       <= ST_READY;
            end
          end
        end
        ST_READY: begin
          // The first read leaves on the swap edge itself, so addr 0 is on the port in cycle 1.
          if (fft_done_i) begin
            state       <= ST_DRAIN;
            hst_rd_en_o <= 1'b1;
            hst_addr_o  <= '0;
            rd_cnt      <= CNT_W'(1);
            ret_cnt     <= '0;
          end
        end
        ST_DRAIN: begin
          if (rd_cnt <= LAST && credit) begin
            hst_rd_en_o <= 1'b1;
            hst_addr_o  <= rd_cnt[P_ADDR_W-1:0];
            rd_cnt      <= rd_cnt + CNT_W'(1);
          end
          if (fifo_pop && res_last_o) begin
            state    <= ST_FILL;
            fill_cnt <= '0;
            rd_cnt   <= '0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_syn_fgyrus_fft_cache_hst_agent.sv
// Scoreboard bench: drivers push expected writes/results, negedge monitors pop and compare.
module tb_syn_fgyrus_fft_cache_hst_agent;
  localparam int DW = 32, AW = 8, N = 256, RD = 2, DEP = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic          fft_done_i = 1'b0, pcm_valid_i = 1'b0, res_ready_i = 1'b1;
  logic [DW-1:0] pcm_data_i = '0;
  logic [AW-1:0] hst_addr_o;
  logic          hst_rd_en_o, hst_wr_en_o, hst_rd_valid_i, pcm_ready_o;
  logic [DW-1:0] hst_wr_data_o, hst_rd_data_i, res_data_o;
  logic          res_valid_o, res_last_o, fill_done_o, sync_err_o;

  always #5 clk = ~clk;

  syn_fgyrus_fft_cache_hst_agent #(
    .P_DATA_W(DW), .P_ADDR_W(AW), .P_NUM_SAMPLES(N), .P_RD_DELAY(RD), .P_FIFO_DEPTH(DEP)
  ) u_dut (
    .clk_ir(clk), .rst_ir(rst), .fft_done_i(fft_done_i),
    .hst_addr_o(hst_addr_o), .hst_rd_en_o(hst_rd_en_o), .hst_wr_en_o(hst_wr_en_o),
    .hst_wr_data_o(hst_wr_data_o), .hst_rd_data_i(hst_rd_data_i), .hst_rd_valid_i(hst_rd_valid_i),
    .pcm_valid_i(pcm_valid_i), .pcm_data_i(pcm_data_i), .pcm_ready_o(pcm_ready_o),
    .res_valid_o(res_valid_o), .res_data_o(res_data_o), .res_last_o(res_last_o),
    .res_ready_i(res_ready_i), .fill_done_o(fill_done_o), .sync_err_o(sync_err_o)
  );

  // Cache host port: fixed read latency RD, contents loaded by the bench at each swap.
  logic [DW-1:0] mem [N];
  logic [RD-1:0] pv;
  logic [DW-1:0] pd [RD];
  always @(posedge clk or posedge rst) begin
    if (rst) pv <= '0;
    else begin
      pv    <= {pv[RD-2:0], hst_rd_en_o};
      pd[0] <= mem[hst_addr_o];
      for (int i = 1; i < RD; i++) pd[i] <= pd[i-1];
    end
  end
  assign hst_rd_valid_i = pv[RD-1];
  assign hst_rd_data_i  = pd[RD-1];

  int compared = 0, mismatched = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [AW+DW-1:0] wq[$];
  logic [DW:0]      rq[$];
  int  cyc = 0, t0 = 0, rmode = 0, iss_base = 0, pop_base = 0;
  int  iss_total = 0, pop_total = 0, last_wr_cyc = 0;
  bit  mon_en = 0, fill_contig = 0, prev_stall = 0;
  logic [DW:0] prev_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       res_ready_i = 1'b1;
      1:       res_ready_i = (cyc % 3 == 0);
      default: res_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    logic [AW+DW-1:0] we;
    logic [DW:0]      re;
    if (rst) begin
      iss_total  = 0;
      pop_total  = 0;
      prev_stall = 0;
    end else if (mon_en) begin
      if (hst_wr_en_o) begin
        chk("host_rd_wr_exclusive", hst_rd_en_o, 0);
        if (wq.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          we = wq.pop_front();
          chk("wr_addr", hst_addr_o, we[AW+DW-1:DW]);
          chk("wr_data", hst_wr_data_o, we[DW-1:0]);
          chk("fill_done", fill_done_o, we[AW+DW-1:DW] == AW'(N - 1));
          if (fill_contig && we[AW+DW-1:DW] != 0) chk("wr_back_to_back", cyc - last_wr_cyc, 1);
          last_wr_cyc = cyc;
        end
      end else if (fill_done_o) chk("fill_done_stray", 1, 0);

      if (hst_rd_en_o) begin
        iss_total++;
        chk("rd_addr", hst_addr_o, iss_total - 1 - iss_base);
        chk("credit_bound", (iss_total - pop_total) <= DEP, 1);
      end

      if (res_valid_o) begin
        if (prev_stall) chk("res_hold", {res_last_o, res_data_o}, prev_res);
        if (res_ready_i) begin
          if (rq.size() == 0) chk("res_unexpected", 1, 0);
          else begin
            re = rq.pop_front();
            chk("res_data", res_data_o, re[DW-1:0]);
            chk("res_last", res_last_o, re[DW]);
            if (rmode == 0) chk("res_cycle", cyc - t0, 4 + pop_total - pop_base);
          end
          pop_total++;
        end
        prev_stall = !res_ready_i;
        prev_res   = {res_last_o, res_data_o};
      end else begin
        if (prev_stall) chk("res_valid_hold", res_valid_o, 1);
        prev_stall = 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2;
    pcm_valid_i = 1'b0;
    fft_done_i  = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_addr", hst_addr_o, 0);
    chk("rst_rd_en", hst_rd_en_o, 0);
    chk("rst_wr_en", hst_wr_en_o, 0);
    chk("rst_wr_data", hst_wr_data_o, 0);
    chk("rst_pcm_ready", pcm_ready_o, 0);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_res_data", res_data_o, 0);
    chk("rst_res_last", res_last_o, 0);
    chk("rst_fill_done", fill_done_o, 0);
    chk("rst_sync_err", sync_err_o, 0);
    wq.delete();
    rq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1 chk("pcm_ready_edge1", pcm_ready_o, 0);
    @(posedge clk); #1 chk("pcm_ready_edge2", pcm_ready_o, 1);
  endtask

  task automatic do_fill(input bit seq, input int err_at);
    int k = 0, guard = 0;
    bit err_sent = 0;
    fill_contig = seq;
    while (k < N && guard < 8 * N) begin
      @(posedge clk); #1;
      guard++;
      pcm_valid_i = seq ? 1'b1 : ($urandom_range(0, 3) != 0);
      pcm_data_i  = seq ? DW'(k) : $urandom;
      fft_done_i  = (k == err_at) && !err_sent;
      if (fft_done_i) err_sent = 1;
      if (pcm_valid_i && pcm_ready_o) begin
        wq.push_back({AW'(k), pcm_data_i});
        k++;
      end
    end
    @(posedge clk); #1;
    pcm_valid_i = 1'b0;
    fft_done_i  = 1'b0;
    chk("fill_count", k, N);
    repeat (2) @(posedge clk);
    #1;
    chk("fill_writes_seen", wq.size(), 0);
    chk("pcm_ready_after_fill", pcm_ready_o, 0);
  endtask

  // kind 0 loads 0xA000_0000+addr, otherwise a random frame; stop_after>0 abandons mid-drain.
  task automatic do_drain(input int mode, input int kind, input int stop_after);
    int g = 0;
    rmode = mode;
    @(posedge clk); #1;
    for (int a = 0; a < N; a++) begin
      mem[a] = (kind == 0) ? 32'hA000_0000 + 32'(a) : $urandom;
      rq.push_back({a == N - 1, mem[a]});
    end
    iss_base   = iss_total;
    pop_base   = pop_total;
    t0         = cyc;
    fft_done_i = 1'b1;
    @(posedge clk); #1 fft_done_i = 1'b0;
    while (rq.size() != 0 && g < 20 * N) begin
      @(posedge clk);
      g++;
      if (stop_after > 0 && pop_total - pop_base > stop_after) break;
    end
    if (stop_after == 0) begin
      chk("drain_complete", rq.size(), 0);
      @(posedge clk); #1;
      chk("fill_after_drain", pcm_ready_o, 1);
      chk("res_idle_after_drain", res_valid_o, 0);
    end else chk("drain_reached_stop", pop_total - pop_base > stop_after, 1);
  endtask

  initial begin
    do_reset();
    mon_en = 1;
    do_fill(1, -1);
    do_drain(0, 0, 0);
    chk("sync_err_clean", sync_err_o, 0);
    do_fill(0, 100);
    chk("sync_err_set", sync_err_o, 1);
    do_drain(1, 1, 0);
    chk("sync_err_sticky", sync_err_o, 1);
    do_fill(0, -1);
    do_drain(2, 1, 50);
    do_reset();
    do_fill(1, -1);
    do_drain(2, 1, 0);
    do_fill(0, -1);
    do_drain(0, 1, 0);
    do_fill(0, -1);
    chk("sync_err_two_frames", sync_err_o, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
